micro_sequencer: RTL and testbench

Microprogram sequencer for the control unit. It owns the micro-program counter (uPC) that addresses the `microcode` memory. Each cycle it evaluates the fetched instruction's condition, branch, call, return and halt fields against the datapath zero flag and computes the next uPC. It sits between the `microcode` ROM (its only address source) and the datapath status flags, and exposes a start/done handshake to the top-level matrix-multiply controller.

---
 rtl/cu_pkg.sv | 16 +
 rtl/ret_stack.sv | 51 +++++
 rtl/micro_sequencer.sv | 135 +++++++++++++
 tb/tb_micro_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Control-unit shared types: sequencer FSM states and microcode condition selects.
// Pure declarations; no logic, latency or flow control of its own.
package cu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam logic [1:0] COND_NEVER  = 2'd0;
    localparam logic [1:0] COND_ALWAYS = 2'd1;
    localparam logic [1:0] COND_Z      = 2'd2;
    localparam logic [1:0] COND_NZ     = 2'd3;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO; push/pop commit on the clock edge, dout shows the current top.
// Caller must not push when full or pop when empty; such requests are dropped.
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

    logic [PW-1:0]   r_cnt;
    logic [W-1:0]    r_mem [DEPTH];
    logic [PW-2:0]   w_wr_idx;
    logic [PW-2:0]   w_top_idx;

    assign w_wr_idx  = r_cnt[PW-2:0];
    // Wraps to DEPTH-1 when empty; dout is unused in that case.
    assign w_top_idx = r_cnt[PW-2:0] - 1'b1;
    assign empty     = (r_cnt == '0);
    assign full      = (r_cnt == FULL_CNT);
    assign dout      = r_mem[w_top_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (push && !full) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (pop && !empty) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[w_wr_idx] <= din;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: owns the uPC, resolves branch/call/return/halt each cycle.
// One uPC update per unstalled RUN cycle; stall freezes uPC, stack, state and stack_err.
module micro_sequencer
    import cu_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] START_ADDR  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              z_flag,
    input  logic [1:0]        condition,
    input  logic              BT,
    input  logic              call,
    input  logic              ret,
    input  logic              halt,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] reg_out,
    output logic              busy,
    output logic              done,
    output logic              stack_err
);

    seq_state_t        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_upc, w_upc_nxt;
    logic              r_err, w_err_nxt;
    logic [ADDR_W-1:0] w_upc_inc;
    logic [ADDR_W-1:0] w_ret_addr;
    logic              w_cond_true, w_taken;
    logic              w_push, w_pop, w_clr;
    logic              w_empty, w_full;

    assign w_upc_inc = r_upc + 1'b1;

    always_comb begin
        case (condition)
            COND_NEVER:  w_cond_true = 1'b0;
            COND_ALWAYS: w_cond_true = 1'b1;
            COND_Z:      w_cond_true = z_flag;
            default:     w_cond_true = !z_flag;
        endcase
    end

    assign w_taken = BT & w_cond_true;

    always_comb begin
        w_state_nxt = r_state;
        w_upc_nxt   = r_upc;
        w_err_nxt   = r_err;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            IDLE: begin
                w_upc_nxt = START_ADDR;
                if (start) begin
                    w_state_nxt = RUN;
                    w_clr       = 1'b1;
                    w_err_nxt   = 1'b0;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (halt) begin
                        w_state_nxt = DONE;
                    end else if (ret) begin
                        if (w_empty) begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = DONE;
                        end else begin
                            w_pop     = 1'b1;
                            w_upc_nxt = w_ret_addr;
                        end
                    end else if (w_taken && call) begin
                        if (w_full) begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = DONE;
                        end else begin
                            w_push    = 1'b1;
                            w_upc_nxt = jump_addr;
                        end
                    end else if (w_taken) begin
                        w_upc_nxt = jump_addr;
                    end else begin
                        w_upc_nxt = w_upc_inc;
                    end
                end
            end
            DONE: begin
                w_upc_nxt   = START_ADDR;
                w_state_nxt = IDLE;
            end
            default: begin
                w_upc_nxt   = START_ADDR;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_upc   <= START_ADDR;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_upc   <= w_upc_nxt;
            r_err   <= w_err_nxt;
        end
    end

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_upc_inc),
        .dout  (w_ret_addr),
        .empty (w_empty),
        .full  (w_full)
    );

    assign reg_out   = r_upc;
    assign busy      = (r_state == RUN);
    assign done      = (r_state == DONE);
    assign stack_err = r_err;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed and randomized microprograms checked against a queue-based sequencer model.
module tb_micro_sequencer;

    typedef struct {
        bit        halt;
        bit        ret;
        bit        call;
        bit        bt;
        bit [1:0]  cond;
        bit [15:0] jmp;
    } uinst_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, stall = 1'b0, z_flag = 1'b0;
    logic [1:0]  condition = '0;
    logic        bt = 1'b0, call = 1'b0, ret = 1'b0, halt = 1'b0;
    logic [15:0] jump_addr = '0;
    logic [15:0] reg_out;
    logic        busy, done, stack_err;

    logic        start2 = 1'b0, zero1 = 1'b0;
    logic [1:0]  zero2 = '0;
    logic [3:0]  zero4 = '0;
    logic [3:0]  reg_out2;
    logic        busy2, done2, err2;

    micro_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .z_flag(z_flag),
        .condition(condition), .BT(bt), .call(call), .ret(ret), .halt(halt),
        .jump_addr(jump_addr), .reg_out(reg_out), .busy(busy), .done(done),
        .stack_err(stack_err)
    );

    micro_sequencer #(.ADDR_W(4), .STACK_DEPTH(4), .START_ADDR(4'd14)) dut_wrap (
        .clk(clk), .reset(reset), .start(start2), .stall(zero1), .z_flag(zero1),
        .condition(zero2), .BT(zero1), .call(zero1), .ret(zero1), .halt(zero1),
        .jump_addr(zero4), .reg_out(reg_out2), .busy(busy2), .done(done2),
        .stack_err(err2)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    uinst_t      rom [128];
    int          n_vec = 0, n_err = 0, n_done = 0;
    int          m_mode;            // 0 idle, 1 running, 2 done pulse
    logic [15:0] m_pc;
    logic [15:0] m_stk [$];
    bit          m_err;
    logic [15:0] trace [$];
    logic [15:0] eq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_rom();
        for (int i = 0; i < 128; i++) rom[i] = '{0, 0, 0, 0, 2'd0, 16'd0};
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pc   = 16'd0;
        m_stk.delete();
        m_err  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        model_reset();
        chk("rst_upc", reg_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", stack_err, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step();
        uinst_t u;
        bit ct, tk, ne;
        int nm;
        logic [15:0] np;
        u = rom[m_pc[6:0]];
        halt = u.halt; ret = u.ret; call = u.call; bt = u.bt;
        condition = u.cond; jump_addr = u.jmp;
        nm = m_mode; np = m_pc; ne = m_err;
        case (u.cond)
            2'd0: ct = 1'b0;
            2'd1: ct = 1'b1;
            2'd2: ct = z_flag;
            default: ct = !z_flag;
        endcase
        tk = u.bt && ct;
        if (m_mode == 0) begin
            if (start) begin
                nm = 1; np = 16'd0; m_stk.delete(); ne = 1'b0;
            end
        end else if (m_mode == 2) begin
            nm = 0; np = 16'd0;
        end else if (!stall) begin
            if (u.halt) nm = 2;
            else if (u.ret) begin
                if (m_stk.size() == 0) begin ne = 1'b1; nm = 2; end
                else np = m_stk.pop_back();
            end else if (tk && u.call) begin
                if (m_stk.size() == 4) begin ne = 1'b1; nm = 2; end
                else begin m_stk.push_back(m_pc + 16'd1); np = u.jmp; end
            end else if (tk) np = u.jmp;
            else np = m_pc + 16'd1;
        end
        @(posedge clk);
        m_mode = nm; m_pc = np; m_err = ne;
        @(negedge clk);
        chk("busy", busy, 32'(m_mode == 1));
        chk("done", done, 32'(m_mode == 2));
        chk("stack_err", stack_err, 32'(m_err));
        if (m_mode != 2) chk("upc", reg_out, m_pc);
        if (busy === 1'b1) trace.push_back(reg_out);
        if (done === 1'b1) n_done++;
    endtask

    task automatic run_prog();
        int k;
        trace.delete();
        n_done = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (m_mode != 0 && k < 300) begin
            step();
            k++;
        end
        chk("run_end_busy", busy, 0);
        chk("run_end_upc", reg_out, 0);
        chk("run_done_pulses", n_done, 1);
    endtask

    task automatic chk_trace(input string tag);
        chk({tag, "_len"}, trace.size(), eq.size());
        for (int i = 0; i < eq.size(); i++)
            chk(tag, (i < trace.size()) ? 32'(trace[i]) : 32'hffff_ffff, eq[i]);
    endtask

    initial begin
        clr_rom();
        model_reset();
        @(negedge clk);
        do_reset();

        // Linear run, halt at 5
        rom[5].halt = 1;
        run_prog();
        eq = {16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
        chk_trace("linear");

        // Conditional branch on Z at address 3
        rom[3] = '{0, 0, 0, 1, 2'd2, 16'h20};
        rom[16'h20].halt = 1;
        z_flag = 1'b1;
        run_prog();
        eq = {16'd0, 16'd1, 16'd2, 16'd3, 16'h20};
        chk_trace("br_z1");
        z_flag = 1'b0;
        run_prog();
        eq = {16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
        chk_trace("br_z0");
        rom[3].cond = 2'd0;
        z_flag = 1'b1;
        run_prog();
        chk_trace("br_never");

        // Call at 2 to 0x40, return at 0x41
        clr_rom();
        rom[2] = '{0, 0, 1, 1, 2'd1, 16'h40};
        rom[16'h41].ret = 1;
        rom[5].halt = 1;
        run_prog();
        eq = {16'd0, 16'd1, 16'd2, 16'h40, 16'h41, 16'd3, 16'd4, 16'd5};
        chk_trace("call_ret");

        // Five nested calls overflow a 4-deep stack
        clr_rom();
        rom[0]       = '{0, 0, 1, 1, 2'd1, 16'h10};
        rom[16'h10]  = '{0, 0, 1, 1, 2'd1, 16'h20};
        rom[16'h20]  = '{0, 0, 1, 1, 2'd1, 16'h30};
        rom[16'h30]  = '{0, 0, 1, 1, 2'd1, 16'h40};
        rom[16'h40]  = '{0, 0, 1, 1, 2'd1, 16'h50};
        run_prog();
        eq = {16'd0, 16'h10, 16'h20, 16'h30, 16'h40};
        chk_trace("overflow");
        chk("overflow_err", stack_err, 1);

        // Return on empty stack
        clr_rom();
        rom[0].ret = 1;
        run_prog();
        chk("underflow_err", stack_err, 1);

        // Next start clears stack_err; then stall over a halt at 7
        clr_rom();
        rom[7].halt = 1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_clears_err", stack_err, 0);
        for (int k = 0; k < 20 && m_pc != 16'd7; k++) step();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_upc", reg_out, 7);
            chk("stall_no_done", done, 0);
        end
        stall = 1'b0;
        step();
        chk("stall_release_done", done, 1);
        step();

        // Asynchronous reset mid-run at address 9
        clr_rom();
        rom[20].halt = 1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 20 && m_pc != 16'd9; k++) step();
        chk("pre_reset_upc", reg_out, 9);
        #2;
        do_reset();
        n_done = 0;
        for (int k = 0; k < 4; k++) step();
        chk("reset_no_done", n_done, 0);

        // Randomized microprograms with random stall, Z and stray starts
        for (int p = 0; p < 30; p++) begin
            int r;
            for (int a = 0; a < 64; a++) begin
                r = $urandom_range(0, 15);
                rom[a] = '{r == 0, r == 1 || r == 2, r == 3 || r == 4, r >= 3 && r <= 7,
                           2'($urandom_range(0, 3)), 16'($urandom_range(0, 63))};
            end
            start = 1'b1;
            step();
            start = 1'b0;
            for (int k = 0; k < 150 && m_mode != 0; k++) begin
                stall  = ($urandom_range(0, 3) == 0);
                z_flag = $urandom_range(0, 1);
                start  = ($urandom_range(0, 7) == 0);
                step();
            end
            start = 1'b0;
            stall = 1'b0;
            if (m_mode != 0) do_reset();
        end

        // Wrap-around on a 4-bit uPC starting at 14
        start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        chk("wrap_busy", busy2, 1);
        chk("wrap_0", reg_out2, 14);
        @(negedge clk);
        chk("wrap_1", reg_out2, 15);
        @(negedge clk);
        chk("wrap_2", reg_out2, 0);
        @(negedge clk);
        chk("wrap_3", reg_out2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
